// File: rtl/mem_req_pkg.sv
// Shared types for the memory request issuer: default widths, command record, FSM states.
package mem_req_pkg;
  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;

  typedef struct packed {
    logic                  rnw;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, GAP} issuer_state_t;
endpackage

// File: rtl/mem_req_issuer_fifo.sv
// sync_fifo: circular command buffer with wrap-around pointers and a separate occupancy count.
module sync_fifo
  import mem_req_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = mem_cmd_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  T                         i_din,
  output T                         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push, w_pop;

  // Guard against overflow/underflow even if a caller misbehaves.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/mem_req_issuer.sv
// Queues producer commands and issues them one at a time to a single-port memory.
// Optional MEM_REQ_ISSUER_STATS_EN adds saturating read/write/stall counters.
module mem_req_issuer
  import mem_req_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_rnw_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              req_o,
  output logic              req_rnw_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [DATA_W-1:0] req_wdata_o,
  input  logic              req_ready_i,
  input  logic [DATA_W-1:0] req_rdata_i,
  output logic              rsp_valid_o,
  output logic [ADDR_W-1:0] rsp_addr_o,
  output logic [DATA_W-1:0] rsp_rdata_o
`ifdef MEM_REQ_ISSUER_STATS_EN
  ,
  output logic [15:0]       rd_cnt_o,
  output logic [15:0]       wr_cnt_o,
  output logic [15:0]       stall_cnt_o
`endif
);
  // Same layout as mem_cmd_t, sized by this instance's widths.
  typedef struct packed {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  issuer_state_t           r_state, w_state_nxt;
  cmd_t                    w_cmd_in, w_head;
  logic                    w_full, w_empty, w_push, w_pop;
  logic [$clog2(DEPTH):0]  w_count;
  logic                    r_rsp_valid;
  logic [ADDR_W-1:0]       r_rsp_addr;
  logic [DATA_W-1:0]       r_rsp_rdata;

  assign cmd_ready_o = !w_full;
  assign w_push      = cmd_valid_i && cmd_ready_o;
  assign w_pop       = (r_state == REQ) && req_ready_i;
  assign w_cmd_in    = '{rnw: cmd_rnw_i, addr: cmd_addr_i, wdata: cmd_wdata_i};

  sync_fifo #(.DEPTH(DEPTH), .T(cmd_t)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_cmd_in),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Request fields are driven from the FIFO head only while in REQ, so they are 0 otherwise.
  always_comb begin
    w_state_nxt = r_state;
    req_o       = 1'b0;
    req_rnw_o   = 1'b0;
    req_addr_o  = '0;
    req_wdata_o = '0;
    case (r_state)
      IDLE: if (!w_empty) w_state_nxt = REQ;
      REQ: begin
        req_o       = 1'b1;
        req_rnw_o   = w_head.rnw;
        req_addr_o  = w_head.addr;
        req_wdata_o = w_head.wdata;
        if (req_ready_i) w_state_nxt = GAP;
      end
      GAP:     w_state_nxt = (w_count != '0) ? REQ : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_pop && w_head.rnw;
      if (w_pop && w_head.rnw) begin
        r_rsp_addr  <= w_head.addr;
        r_rsp_rdata <= req_rdata_i;
      end
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_addr_o  = r_rsp_addr;
  assign rsp_rdata_o = r_rsp_rdata;

`ifdef MEM_REQ_ISSUER_STATS_EN
  logic [15:0] r_rd_cnt, r_wr_cnt, r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop && w_head.rnw && r_rd_cnt != 16'hFFFF)   r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_pop && !w_head.rnw && r_wr_cnt != 16'hFFFF)  r_wr_cnt <= r_wr_cnt + 16'd1;
      if (r_state == REQ && !req_ready_i && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign rd_cnt_o    = r_rd_cnt;
  assign wr_cnt_o    = r_wr_cnt;
  assign stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: doc/mem_req_issuer.md
Name: mem_req_issuer

Overview:
Command-queue stage directly upstream of the single-port memory request interface (req / rnw / addr / wdata, ready / rdata).
Accepts read/write commands from a producer via valid/ready and buffers them in a small FIFO. Drives them one at a time onto the memory request port, holding each request stable until ready. Returns read data to the producer as a registered response.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >= 2
ADDR_W, 10, memory word address width
DATA_W, 32, data width

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid_i  input  1  producer command valid
cmd_ready_o  output  1  FIFO can accept a command (= not full)
cmd_rnw_i  input  1  1 = read, 0 = write
cmd_addr_i  input  ADDR_W  command address
cmd_wdata_i  input  DATA_W  write data (don't-care for reads)
req_o  output  1  request to memory
req_rnw_o  output  1  request type
req_addr_o  output  ADDR_W  request address
req_wdata_o  output  DATA_W  request write data
req_ready_i  input  1  memory completes current request this cycle
req_rdata_i  input  DATA_W  read data, valid in the cycle req_o && req_ready_i && req_rnw_o
rsp_valid_o  output  1  one-cycle pulse, read response valid
rsp_addr_o  output  ADDR_W  address of the completed read
rsp_rdata_o  output  DATA_W  read data

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset values: req_o=0, rsp_valid_o=0, FIFO count=0, so cmd_ready_o=1 in the first cycle after reset. req_rnw_o, req_addr_o, req_wdata_o, rsp_addr_o and rsp_rdata_o all reset to 0.
- Push: occurs when cmd_valid_i && cmd_ready_o. cmd_ready_o = (count != DEPTH), combinational from registered count.
- FIFO: circular buffer with wrap-around read/write pointers of log2(DEPTH) bits, plus a separate count of log2(DEPTH)+1 bits.
- FSM states:
  - IDLE: req_o=0. If count != 0, go to REQ on the next cycle.
  - REQ: req_o=1. req_rnw_o, req_addr_o and req_wdata_o come from the FIFO head and stay stable while req_ready_i=0. When req_ready_i=1: handshake, pop head, go to GAP.
  - GAP: req_o=0 for exactly one cycle. Then go to REQ if count != 0 after the pop, else IDLE.
- Minimum spacing: one command per 2 cycles when the memory is ready immediately. Latency from push into an empty FIFO to req_o=1 is 2 cycles (push edge, then IDLE->REQ edge).
- Read response: registered at the handshake edge. rsp_valid_o=1 in the cycle after a read handshake; rsp_rdata_o = req_rdata_i sampled at that edge; rsp_addr_o = the head address. Writes produce no response. rsp_* data holds until the next read response.
- Simultaneous push and pop in the same cycle: both take effect and count is unchanged.
- Push attempted while full: cmd_ready_o=0, so the command is not accepted and no state changes.
- Pop while the FIFO is being written to from empty: not possible; REQ is only entered with count != 0.
- Reset mid-REQ: req_o=0 the next cycle and all queued commands are discarded. The memory side must tolerate an abandoned request.
- req_ready_i while req_o=0: ignored.

Optional Feature:
MEM_REQ_ISSUER_STATS_EN:
- Defined: adds outputs rd_cnt_o[15:0] and wr_cnt_o[15:0].
  - Each counts completed handshakes of its type.
  - Each saturates at 16'hFFFF and resets to 0.
  - Also adds stall_cnt_o[15:0]: saturating count of REQ cycles with req_ready_i=0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package mem_req_pkg:
  - ADDR_W and DATA_W defaults.
  - typedef mem_cmd_t, a packed struct {rnw, addr, wdata}.
  - typedef enum issuer_state_t {IDLE, REQ, GAP}.
- Natural sub-module: sync_fifo (parameterised by DEPTH and element type mem_cmd_t), exposing push/pop/full/empty/count and a head output. The FSM and response register stay in mem_req_issuer.

Test Plan:
- Reset then idle: after reset, cmd_ready_o=1, req_o=0 and rsp_valid_o=0 for 5 cycles with no commands.
- Single write, memory ready: push write addr=10'h155 wdata=32'hDEADBEEF, req_ready_i=1 always.
  - req_o=1 exactly one cycle, 2 cycles after push, with those fields.
  - No rsp_valid_o.
- Read with stall: push read addr=10'h3FF; hold req_ready_i=0 for 3 REQ cycles, then 1 with req_rdata_i=32'h0000CAFE.
  - req_o held 4 cycles with fields stable.
  - rsp_valid_o pulses once next cycle with rsp_addr_o=10'h3FF, rsp_rdata_o=32'h0000CAFE.
- Full FIFO: push 5 commands back-to-back with req_ready_i=0.
  - First 4 accepted; cmd_ready_o=0 while full, so the 5th is held by the producer.
  - Release ready: commands issue in order with a one-cycle req_o=0 gap between each.
- Wrap-around ordering: 10 writes to random addresses, then 10 reads of the same addresses, with ready held on.
  - Issue order matches push order.
  - Read responses return the written data from a memory model.
- Reset mid-REQ: 3 commands queued with ready low; assert reset for 1 cycle.
  - req_o=0 the next cycle, count=0, no responses.
  - With STATS_EN defined, counters read 0.
